// File: rtl/parking_pkg.sv
// Shared types and sizing for the parking lot occupancy controller.
// Slot and capacity widths follow from the slot count.
package parking_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W =
    (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CAP_W = $clog2(NUM_SLOTS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTER = 2'd1,
    S_EXIT  = 2'd2,
    S_FULL  = 2'd3
  } state_t;

endpackage

// File: rtl/parking_fsm_if.sv
// Gate/keypad request bundle and display/actuator status bundle.
// master drives requests, slave is the occupancy controller.
interface parking_fsm_if #(
  parameter int NUM_SLOTS = 4
) ();

  localparam int SW =
    (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = $clog2(NUM_SLOTS + 1);

  logic                 entry_signal;
  logic                 exit_signal;
  logic [SW-1:0]        exit_slot;
  logic                 is_open;
  logic                 is_full;
  logic [NUM_SLOTS-1:0] spots;
  logic [CW-1:0]        capacity;
  logic [SW-1:0]        location;

  modport master (
    output entry_signal,
    output exit_signal,
    output exit_slot,
    input  is_open,
    input  is_full,
    input  spots,
    input  capacity,
    input  location
  );

  modport slave (
    input  entry_signal,
    input  exit_signal,
    input  exit_slot,
    output is_open,
    output is_full,
    output spots,
    output capacity,
    output location
  );

endinterface

// File: rtl/parking_fsm_slot_allocator.sv
// Lowest-free-slot priority encoder over an occupancy mask.
// found is low when every slot is taken; idx is then 0.
module slot_allocator #(
  parameter int NUM_SLOTS = 4,
  parameter int SW =
    (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic [NUM_SLOTS-1:0] mask,
  output logic [SW-1:0]        idx,
  output logic                 found
);

  // Scan high to low so the lowest free index wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!mask[i]) begin
        idx   = SW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_fsm.sv
// Parking lot occupancy controller: exits free a slot, then an
// entry takes the lowest free slot; all outputs are registered.
module parking_fsm #(
  parameter int NUM_SLOTS = parking_pkg::NUM_SLOTS
) (
  input logic           clk,
  input logic           reset,
  parking_fsm_if.slave  bus
);

  import parking_pkg::*;

  localparam int SW =
    (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = $clog2(NUM_SLOTS + 1);

  logic [NUM_SLOTS-1:0] spots_q;
  logic [CW-1:0]        cap_q;
  logic [SW-1:0]        loc_q;
  logic                 full_q;
  state_t               state_q;

  logic                 exit_ok;
  logic                 entry_ok;
  logic [NUM_SLOTS-1:0] spots_x;
  logic [CW-1:0]        cap_x;
  logic [NUM_SLOTS-1:0] spots_n;
  logic [CW-1:0]        cap_n;
  logic [SW-1:0]        loc_n;
  state_t               state_n;
  logic [SW-1:0]        free_idx;
  logic                 free_ok;

  // Exit resolves first so an entry can reuse the vacated slot.
  always_comb begin
    exit_ok = bus.exit_signal && spots_q[bus.exit_slot];
    spots_x = spots_q;
    cap_x   = cap_q;
    if (exit_ok) begin
      spots_x[bus.exit_slot] = 1'b0;
      cap_x = cap_q + CW'(1);
    end
  end

  slot_allocator #(
    .NUM_SLOTS (NUM_SLOTS),
    .SW        (SW)
  ) u_alloc (
    .mask  (spots_x),
    .idx   (free_idx),
    .found (free_ok)
  );

  always_comb begin
    entry_ok = bus.entry_signal && free_ok;
    spots_n  = spots_x;
    cap_n    = cap_x;
    loc_n    = loc_q;
    if (entry_ok) begin
      spots_n[free_idx] = 1'b1;
      cap_n = cap_x - CW'(1);
      loc_n = free_idx;
    end
  end

  always_comb begin
    state_n = S_IDLE;
    if (entry_ok) begin
      state_n = S_ENTER;
    end else if (exit_ok) begin
      state_n = S_EXIT;
    end else if (cap_n == '0) begin
      state_n = S_FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      spots_q <= '0;
      cap_q   <= CW'(NUM_SLOTS);
      loc_q   <= '0;
      full_q  <= 1'b0;
      state_q <= S_IDLE;
    end else begin
      spots_q <= spots_n;
      cap_q   <= cap_n;
      loc_q   <= loc_n;
      full_q  <= (cap_n == '0);
      state_q <= state_n;
    end
  end

  assign bus.spots    = spots_q;
  assign bus.capacity = cap_q;
  assign bus.location = loc_q;
  assign bus.is_full  = full_q;
  assign bus.is_open  =
    (state_q == S_ENTER) || (state_q == S_EXIT);

endmodule

// File: tb/tb_parking_fsm.sv
// Directed-vector bench for parking_fsm with hand-computed
// expected bitmap, capacity, location, door and full values.
module tb_parking_fsm;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  parking_fsm_if #(.NUM_SLOTS(4)) bus ();

  parking_fsm #(.NUM_SLOTS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  // vec = {entry, exit, exit_slot}; one edge, then sample.
  task automatic step(
    input string    tag,
    input logic     rst,
    input logic [3:0] vec,
    input logic [3:0] e_spots,
    input logic [2:0] e_cap,
    input logic [1:0] e_loc,
    input logic     e_open,
    input logic     e_full
  );
    reset            = rst;
    bus.entry_signal = vec[3];
    bus.exit_signal  = vec[2];
    bus.exit_slot    = vec[1:0];
    @(posedge clk);
    #1;
    check({tag, ".spots"}, 32'(bus.spots), 32'(e_spots));
    check({tag, ".cap"}, 32'(bus.capacity), 32'(e_cap));
    check({tag, ".loc"}, 32'(bus.location), 32'(e_loc));
    check({tag, ".open"}, 32'(bus.is_open), 32'(e_open));
    check({tag, ".full"}, 32'(bus.is_full), 32'(e_full));
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    bus.entry_signal = 1'b0;
    bus.exit_signal  = 1'b0;
    bus.exit_slot    = 2'd0;

    step("rst0", 1, 4'b0000, 4'b0000, 3'd4, 2'd0, 0, 0);
    step("rst1", 1, 4'b0000, 4'b0000, 3'd4, 2'd0, 0, 0);
    step("idle0", 0, 4'b0000, 4'b0000, 3'd4, 2'd0, 0, 0);
    step("idle1", 0, 4'b0000, 4'b0000, 3'd4, 2'd0, 0, 0);

    step("ent0", 0, 4'b1000, 4'b0001, 3'd3, 2'd0, 1, 0);
    step("ent1", 0, 4'b1000, 4'b0011, 3'd2, 2'd1, 1, 0);
    step("ent2", 0, 4'b1000, 4'b0111, 3'd1, 2'd2, 1, 0);
    step("ent3", 0, 4'b1000, 4'b1111, 3'd0, 2'd3, 1, 1);

    step("ent_full", 0, 4'b1000, 4'b1111, 3'd0, 2'd3, 0, 1);
    step("idle_full", 0, 4'b0000, 4'b1111, 3'd0, 2'd3, 0, 1);
    // From full, a swap reuses the vacated slot 2.
    step("swap_full", 0, 4'b1110, 4'b1111, 3'd0, 2'd2, 1, 1);

    step("exit1", 0, 4'b0101, 4'b1101, 3'd1, 2'd2, 1, 0);
    step("exit1_rep", 0, 4'b0101, 4'b1101, 3'd1, 2'd2, 0, 0);

    // Slot 2 vacated, but slot 1 is the lowest free.
    step("swap2", 0, 4'b1110, 4'b1011, 3'd1, 2'd1, 1, 0);
    step("swap1", 0, 4'b1101, 4'b1011, 3'd1, 2'd1, 1, 0);
    step("idle2", 0, 4'b0000, 4'b1011, 3'd1, 2'd1, 0, 0);

    step("exit3", 0, 4'b0111, 4'b0011, 3'd2, 2'd1, 1, 0);
    step("exit0", 0, 4'b0100, 4'b0010, 3'd3, 2'd1, 1, 0);
    step("exit0_rep", 0, 4'b0100, 4'b0010, 3'd3, 2'd1, 0, 0);
    step("ent_lo", 0, 4'b1000, 4'b0011, 3'd2, 2'd0, 1, 0);
    step("ent_hi", 0, 4'b1000, 4'b0111, 3'd1, 2'd2, 1, 0);

    step("rst_mid", 1, 4'b1000, 4'b0000, 3'd4, 2'd0, 0, 0);
    step("post_rst", 0, 4'b0000, 4'b0000, 3'd4, 2'd0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
